// File: rtl/axis_coincidence_reader_pkg.sv
// rtl/axis_coincidence_reader_pkg.sv - shared helpers for the coincidence reader family
package axis_coincidence_reader_pkg;

    // Status counters stick at all-ones instead of wrapping back to zero
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/axis_coincidence_popcount.sv
// rtl/axis_coincidence_popcount.sv - group-OR of a hit pattern followed by a popcount of the groups
module axis_coincidence_popcount #(
    parameter int DET_WIDTH = 64,
    parameter int GROUPS    = 4
) (
    input  logic [DET_WIDTH-1:0]          pattern,
    output logic [$clog2(GROUPS+1)-1:0]   active_groups
);
    localparam int GW = DET_WIDTH / GROUPS;
    localparam int SW = $clog2(GROUPS + 1);

    logic [GROUPS-1:0] group_hit;

    // A group is active when any of its GW contiguous channels fired
    always_comb begin
        group_hit = '0;
        for (int g = 0; g < GROUPS; g++) begin
            group_hit[g] = |pattern[g*GW +: GW];
        end
    end

    // Count active groups
    always_comb begin
        active_groups = '0;
        for (int g = 0; g < GROUPS; g++) begin
            active_groups = active_groups + SW'(group_hit[g]);
        end
    end

endmodule

// File: rtl/axis_coincidence_reader.sv
// rtl/axis_coincidence_reader.sv - coincidence window, group level check and AXI-Stream event output
module axis_coincidence_reader #(
    parameter int DET_WIDTH  = 64,
    parameter int GROUPS     = 4,
    parameter int TIME_WIDTH = 64,
    parameter int CNTR_WIDTH = 8
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [DET_WIDTH-1:0]            det_data,
    input  logic [CNTR_WIDTH-1:0]           cfg_window,
    input  logic [$clog2(GROUPS+1)-1:0]     cfg_level,
    input  logic [CNTR_WIDTH-1:0]           cfg_dead,
    output logic [TIME_WIDTH+DET_WIDTH-1:0] m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [31:0]                     sts_sent,
    output logic [31:0]                     sts_rejected
);
    import axis_coincidence_reader_pkg::*;

    localparam int SW = $clog2(GROUPS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_EVAL,
        S_DECIDE,
        S_SEND,
        S_DEAD
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [TIME_WIDTH-1:0]   timestamp;
    logic [TIME_WIDTH-1:0]   ts_r;
    logic [DET_WIDTH-1:0]    pattern;
    logic [CNTR_WIDTH-1:0]   cnt;
    logic [SW-1:0]           group_count;
    logic [SW-1:0]           sum_r;
    logic                    accept;
    logic                    handshake;

    axis_coincidence_popcount #(
        .DET_WIDTH (DET_WIDTH),
        .GROUPS    (GROUPS)
    ) u_popcount (
        .pattern       (pattern),
        .active_groups (group_count)
    );

    // Free-running timestamp, never stalls
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            timestamp <= '0;
        end else begin
            timestamp <= timestamp + 1'b1;
        end
    end

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and decision strobes
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        handshake = 1'b0;
        case (state)
            S_IDLE: begin
                if (|det_data) begin
                    state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (cnt >= cfg_window) begin
                    state_nxt = S_EVAL;
                end
            end
            S_EVAL: begin
                state_nxt = S_DECIDE;
            end
            S_DECIDE: begin
                accept = (sum_r >= cfg_level);
                if (accept) begin
                    state_nxt = S_SEND;
                end else begin
                    state_nxt = (cfg_dead == '0) ? S_IDLE : S_DEAD;
                end
            end
            S_SEND: begin
                handshake = m_axis_tready;
                if (m_axis_tready) begin
                    state_nxt = (cfg_dead == '0) ? S_IDLE : S_DEAD;
                end
            end
            S_DEAD: begin
                if (cnt >= cfg_dead) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Pattern accumulation, counters, output register and status
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ts_r          <= '0;
            pattern       <= '0;
            cnt           <= '0;
            sum_r         <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            sts_sent      <= '0;
            sts_rejected  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    pattern <= det_data;
                    cnt     <= '0;
                    if (|det_data) begin
                        ts_r <= timestamp;
                    end
                end
                S_ACCUM: begin
                    pattern <= pattern | det_data;
                    cnt     <= cnt + 1'b1;
                end
                S_EVAL: begin
                    sum_r <= group_count;
                end
                S_DECIDE: begin
                    if (accept) begin
                        m_axis_tdata  <= {ts_r, pattern};
                        m_axis_tvalid <= 1'b1;
                    end else begin
                        sts_rejected <= sat_inc32(sts_rejected);
                        cnt          <= CNTR_WIDTH'(1);
                    end
                end
                S_SEND: begin
                    if (handshake) begin
                        m_axis_tvalid <= 1'b0;
                        sts_sent      <= sat_inc32(sts_sent);
                        cnt           <= CNTR_WIDTH'(1);
                    end
                end
                S_DEAD: begin
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule
